// File: rtl/spi_master_cmd.sv
// SPI mode-0 initiator: sends an 8-bit command plus DATA_W data bits MSB first under ncs,
// and captures the responder's status byte and read data from miso.
module spi_master_cmd #(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned CS_SETUP = 2,
   parameter int unsigned CS_HOLD  = 2,
   parameter int unsigned CS_GAP   = 3,
   parameter int unsigned DATA_W   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        cmd,
   input  logic [DATA_W-1:0] data_in,
   output logic              busy,
   output logic              done,
   output logic [7:0]        stat_out,
   output logic [DATA_W-1:0] data_out,
   output logic              sck,
   output logic              mosi,
   output logic              ncs,
   input  logic              miso
);

   localparam int unsigned FRAME_W = 8 + DATA_W;
   localparam int unsigned CNT_W   = 8;

   localparam logic [CNT_W-1:0] DIV_LD   = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP - 1);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD - 1);
   localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(CS_GAP - 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      LOW   = 3'd2,
      HIGH  = 3'd3,
      HOLD  = 3'd4,
      GAP   = 3'd5
   } state_t;

   state_t              state, state_d;
   logic [CNT_W-1:0]    cnt, cnt_d;
   logic [CNT_W-1:0]    bit_cnt, bit_cnt_d;
   logic [FRAME_W-1:0]  tx_sr, tx_sr_d;
   logic [FRAME_W-1:0]  rx_sr, rx_sr_d;
   logic                sck_d, mosi_d, ncs_d, busy_d, done_d;
   logic [7:0]          stat_d;
   logic [DATA_W-1:0]   data_d;

   // State and all outputs are registered here
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         bit_cnt  <= '0;
         tx_sr    <= '0;
         rx_sr    <= '0;
         sck      <= 1'b0;
         mosi     <= 1'b0;
         ncs      <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         stat_out <= '0;
         data_out <= '0;
      end else begin
         state    <= state_d;
         cnt      <= cnt_d;
         bit_cnt  <= bit_cnt_d;
         tx_sr    <= tx_sr_d;
         rx_sr    <= rx_sr_d;
         sck      <= sck_d;
         mosi     <= mosi_d;
         ncs      <= ncs_d;
         busy     <= busy_d;
         done     <= done_d;
         stat_out <= stat_d;
         data_out <= data_d;
      end
   end

   // Next-state and next-output logic; every phase counter counts down to zero
   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      bit_cnt_d = bit_cnt;
      tx_sr_d   = tx_sr;
      rx_sr_d   = rx_sr;
      sck_d     = sck;
      mosi_d    = mosi;
      ncs_d     = ncs;
      busy_d    = busy;
      done_d    = 1'b0;
      stat_d    = stat_out;
      data_d    = data_out;

      case (state)
         IDLE: begin
            if (start) begin
               tx_sr_d   = {cmd, data_in};
               bit_cnt_d = '0;
               ncs_d     = 1'b0;
               busy_d    = 1'b1;
               mosi_d    = cmd[7];
               if (CS_SETUP == 0) begin
                  state_d = LOW;
                  cnt_d   = DIV_LD;
               end else begin
                  state_d = SETUP;
                  cnt_d   = SETUP_LD;
               end
            end
         end

         SETUP: begin
            if (cnt == '0) begin
               state_d = LOW;
               cnt_d   = DIV_LD;
            end else begin
               cnt_d = cnt - CNT_W'(1);
            end
         end

         LOW: begin
            if (cnt == '0) begin
               sck_d   = 1'b1;
               state_d = HIGH;
               cnt_d   = DIV_LD;
            end else begin
               cnt_d = cnt - CNT_W'(1);
            end
         end

         // miso is sampled at the very end of the high phase to absorb responder sync latency
         HIGH: begin
            if (cnt == '0) begin
               rx_sr_d   = {rx_sr[FRAME_W-2:0], miso};
               tx_sr_d   = tx_sr << 1;
               sck_d     = 1'b0;
               bit_cnt_d = bit_cnt + CNT_W'(1);
               if (bit_cnt == LAST_BIT) begin
                  mosi_d  = 1'b0;
                  state_d = HOLD;
                  cnt_d   = HOLD_LD;
               end else begin
                  mosi_d  = tx_sr[FRAME_W-2];
                  state_d = LOW;
                  cnt_d   = DIV_LD;
               end
            end else begin
               cnt_d = cnt - CNT_W'(1);
            end
         end

         HOLD: begin
            if (cnt == '0) begin
               ncs_d  = 1'b1;
               done_d = 1'b1;
               stat_d = rx_sr[FRAME_W-1:DATA_W];
               data_d = rx_sr[DATA_W-1:0];
               if (CS_GAP == 0) begin
                  busy_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  state_d = GAP;
                  cnt_d   = GAP_LD;
               end
            end else begin
               cnt_d = cnt - CNT_W'(1);
            end
         end

         GAP: begin
            if (cnt == '0) begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt - CNT_W'(1);
            end
         end

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_spi_master_cmd.sv
// Directed self-checking bench for spi_master_cmd: loopback, responder model,
// back-to-back starts, ignored start while busy, and mid-frame reset.
module tb_spi_master_cmd;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  cmd;
   logic [31:0] data_in;
   logic        busy;
   logic        done;
   logic [7:0]  stat_out;
   logic [31:0] data_out;
   logic        sck;
   logic        mosi;
   logic        ncs;
   logic        miso;

   logic        loop;
   logic        resp_miso;
   logic [39:0] resp_word;
   logic [39:0] resp_in;
   int          fall_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   int rises      = 0;
   int rises_idle = 0;
   int ncs_low    = 0;
   int dones      = 0;
   logic sck_q    = 1'b0;

   spi_master_cmd #(
      .CLK_DIV (4),
      .CS_SETUP(2),
      .CS_HOLD (2),
      .CS_GAP  (3),
      .DATA_W  (32)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .cmd     (cmd),
      .data_in (data_in),
      .busy    (busy),
      .done    (done),
      .stat_out(stat_out),
      .data_out(data_out),
      .sck     (sck),
      .mosi    (mosi),
      .ncs     (ncs),
      .miso    (miso)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign miso = loop ? mosi : resp_miso;

   // Responder model: drives its word MSB first, advancing on each sck fall
   always @(negedge sck or posedge ncs) begin
      if (ncs) fall_cnt <= 0;
      else     fall_cnt <= fall_cnt + 1;
   end
   assign resp_miso = (fall_cnt < 40) ? resp_word[39 - fall_cnt] : 1'b0;

   always @(posedge sck) begin
      if (!ncs) resp_in <= {resp_in[38:0], mosi};
   end

   // Bus activity monitor sampled on the falling clock edge
   always @(negedge clk) begin
      if (sck && !sck_q) rises <= rises + 1;
      if (sck && !sck_q && ncs) rises_idle <= rises_idle + 1;
      if (!ncs) ncs_low <= ncs_low + 1;
      if (done) dones <= dones + 1;
      sck_q <= sck;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else
         n_pass++;
   endtask

   // One transaction; optional extra start pulse at cycle inj_at, reset at cycle rst_at
   task automatic run_txn(input logic [7:0] c, input logic [31:0] d,
                          input int inj_at, input int rst_at, output int lat);
      lat = -1;
      @(negedge clk);
      cmd     = c;
      data_in = d;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start   = 1'b0;
      cmd     = ~c;
      data_in = ~d;
      for (int k = 1; k <= 2000; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = k;
            break;
         end
         if (k == rst_at) begin
            rst_n = 1'b0;
            return;
         end
         if (k == inj_at)          start = 1'b1;
         else if (k == inj_at + 1) start = 1'b0;
      end
   endtask

   task automatic wait_idle(output int n);
      n = -1;
      for (int k = 1; k <= 500; k++) begin
         @(posedge clk);
         #1;
         if (!busy) begin
            n = k;
            break;
         end
      end
   endtask

   int lat, n, r0, l0, d0, b0;
   int dn, hi_run, gi;
   int gaps [2];

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      cmd       = '0;
      data_in   = '0;
      loop      = 1'b1;
      resp_word = {8'h5A, 32'hDEADBEEF};
      resp_in   = '0;
      fall_cnt  = 0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_ncs",  64'(ncs), 64'd1);
      check("rst_sck",  64'(sck), 64'd0);
      check("rst_mosi", 64'(mosi), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_stat", 64'(stat_out), 64'd0);
      check("rst_data", 64'(data_out), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Loopback frame timing and capture
      r0 = rises; l0 = ncs_low;
      run_txn(8'hA4, 32'h24AF55AA, 0, 0, lat);
      check("lb_latency", 64'(lat), 64'd324);
      check("lb_stat",    64'(stat_out), 64'hA4);
      check("lb_data",    64'(data_out), 64'h24AF55AA);
      check("lb_rises",   64'(rises - r0), 64'd40);
      check("lb_ncs_low", 64'(ncs_low - l0), 64'd324);
      check("lb_mosi_end", 64'(mosi), 64'd0);
      wait_idle(n);
      check("lb_busy_tail", 64'(n), 64'd3);

      // Responder returning status and read data
      loop = 1'b0;
      run_txn(8'h55, 32'h01234567, 0, 0, lat);
      check("rsp_latency", 64'(lat), 64'd324);
      check("rsp_model_rx", 64'(resp_in), 64'h55_01234567);
      check("rsp_stat", 64'(stat_out), 64'h5A);
      check("rsp_data", 64'(data_out), 64'hDEADBEEF);
      wait_idle(n);
      check("rsp_busy_tail", 64'(n), 64'd3);

      // start held high: three back-to-back frames
      loop = 1'b1;
      r0 = rises; b0 = rises_idle;
      dn = 0; hi_run = 0; gi = 0;
      gaps[0] = -1; gaps[1] = -1;
      @(negedge clk);
      cmd = 8'h81; data_in = 32'h12345678; start = 1'b1;
      for (int k = 0; k < 3000 && dn < 3; k++) begin
         @(posedge clk);
         #1;
         if (done) dn++;
         if (ncs) hi_run++;
         else begin
            if (hi_run > 0 && dn > 0 && gi < 2) begin
               gaps[gi] = hi_run;
               gi++;
            end
            hi_run = 0;
         end
      end
      start = 1'b0;
      check("b2b_dones", 64'(dn), 64'd3);
      check("b2b_gap0", 64'(gaps[0]), 64'd4);
      check("b2b_gap1", 64'(gaps[1]), 64'd4);
      wait_idle(n);
      check("b2b_rises", 64'(rises - r0), 64'd120);
      check("b2b_idle_rises", 64'(rises_idle - b0), 64'd0);
      check("b2b_stat", 64'(stat_out), 64'h81);
      check("b2b_data", 64'(data_out), 64'h12345678);

      // start pulsed mid-frame must be ignored
      d0 = dones;
      run_txn(8'h3C, 32'h0F0F1234, 50, 0, lat);
      check("inj_latency", 64'(lat), 64'd324);
      check("inj_stat", 64'(stat_out), 64'h3C);
      check("inj_data", 64'(data_out), 64'h0F0F1234);
      wait_idle(n);
      repeat (20) @(posedge clk);
      #1;
      check("inj_one_done", 64'(dones - d0), 64'd1);
      check("inj_ncs_idle", 64'(ncs), 64'd1);
      check("inj_busy_idle", 64'(busy), 64'd0);

      // Asynchronous reset during bit 17 (sck high at that moment)
      d0 = dones;
      run_txn(8'hC3, 32'h89ABCDEF, 0, 143, lat);
      #1;
      check("arst_ncs",  64'(ncs), 64'd1);
      check("arst_sck",  64'(sck), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_done", 64'(done), 64'd0);
      check("arst_stat", 64'(stat_out), 64'd0);
      check("arst_data", 64'(data_out), 64'd0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("arst_no_done", 64'(dones - d0), 64'd0);
      run_txn(8'h7E, 32'hCAFEF00D, 0, 0, lat);
      check("post_latency", 64'(lat), 64'd324);
      check("post_stat", 64'(stat_out), 64'h7E);
      check("post_data", 64'(data_out), 64'hCAFEF00D);
      wait_idle(n);
      check("post_busy_tail", 64'(n), 64'd3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
